// File: rtl/jacobi_pkg.sv
// rtl/jacobi_pkg.sv - Shared defaults, FSM encoding and helpers for the jacobi host sequencer
package jacobi_pkg;

    localparam int JACOBI_DW = 27;
    localparam int JACOBI_AW = 15;
    localparam int JACOBI_RW = 7;
    localparam int NMAX      = 127;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GO,
        S_B_LO,
        S_B_HI,
        S_BF_LO,
        S_BF_HI,
        S_A_LO,
        S_A_HI,
        S_AF_LO,
        S_AF_HI,
        S_WAIT,
        S_CAP,
        S_FIN
    } state_t;

    // A zero request still runs a 1x1 problem; oversize requests clamp to NMAX.
    function automatic logic [6:0] clamp_n(input logic [7:0] n);
        if (n == 8'd0) begin
            return 7'd1;
        end else if (n > 8'(NMAX)) begin
            return 7'(NMAX);
        end else begin
            return n[6:0];
        end
    endfunction

endpackage

// File: rtl/jacobi_strobe_gen.sv
// rtl/jacobi_strobe_gen.sv - LO/HI load strobe with element counter and terminal count
module jacobi_strobe_gen
    import jacobi_pkg::*;
#(
    parameter int CW = $clog2(NMAX * NMAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          lo,
    input  logic          step,
    input  logic [CW-1:0] last_idx,
    output logic          strobe,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == last_idx);

    // A flush pulse drives lo without step, so the strobe repeats while the count holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe <= 1'b0;
            cnt    <= '0;
        end else begin
            strobe <= lo;
            if (clr) begin
                cnt <= '0;
            end else if (step && !tc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/jacobi_host_seq.sv
// rtl/jacobi_host_seq.sv - Host-side load/capture sequencer for jacobi_iter (JACOBI_HOST_LAT_EN adds lat_cycles)
module jacobi_host_seq
    import jacobi_pkg::*;
#(
    parameter int DW    = JACOBI_DW,
    parameter int AW    = JACOBI_AW,
    parameter int RW    = JACOBI_RW,
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       n_in,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic [AW-1:0]    src_addr,
    output logic             src_rd,
    input  logic [DW-1:0]    src_rdata,
    output logic             go,
    output logic             load_A,
    output logic             load_B,
    output logic [DW-1:0]    A_next,
    output logic [DW-1:0]    B_next,
    input  logic             drdy,
    input  logic             fail,
    input  logic [DW-1:0]    dout,
    output logic             res_we,
    output logic [RW-1:0]    res_addr,
    output logic [DW-1:0]    res_wdata,
    output logic             busy,
    output logic             done,
    output logic             solve_fail,
    output logic             timeout
`ifdef JACOBI_HOST_LAT_EN
    ,
    output logic [15:0]      lat_cycles
`endif
);

    localparam int CW = $clog2(NMAX * NMAX);

    state_t           state, state_nxt;
    logic [6:0]       n_q;
    logic [6:0]       n_m1;
    logic [CW-1:0]    nn_full;
    logic [CW-1:0]    nn_m1;
    logic [TMO_W-1:0] wcnt;
    logic [TMO_W-1:0] wcnt_inc;
    logic             tmo_hit;
    logic [RW-1:0]    res_next;
    logic             cap_last;

    logic             sg_clr, sg_lo, sg_step, sg_strobe, sg_tc;
    logic [CW-1:0]    sg_cnt, sg_last;

    assign n_m1     = n_q - 7'd1;
    assign nn_full  = CW'(n_q) * CW'(n_q);
    assign wcnt_inc = wcnt + TMO_W'(1);
    assign tmo_hit  = (tmo_limit != '0) && (wcnt_inc == tmo_limit);
    assign res_next = res_addr + RW'(1);
    assign cap_last = (res_next == RW'(n_m1));
    assign sg_last  = (state == S_A_LO || state == S_A_HI) ? nn_m1 : CW'(n_m1);

    jacobi_strobe_gen #(.CW(CW)) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .clr      (sg_clr),
        .lo       (sg_lo),
        .step     (sg_step),
        .last_idx (sg_last),
        .strobe   (sg_strobe),
        .cnt      (sg_cnt),
        .tc       (sg_tc)
    );

    assign load_B = sg_strobe && (state == S_B_HI || state == S_BF_HI);
    assign load_A = sg_strobe && (state == S_A_HI || state == S_AF_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        src_rd    = 1'b0;
        src_addr  = '0;
        sg_clr    = 1'b0;
        sg_lo     = 1'b0;
        sg_step   = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                go        = 1'b1;
                src_rd    = 1'b1;
                sg_clr    = 1'b1;
                state_nxt = S_B_LO;
            end
            S_B_LO: begin
                sg_lo     = 1'b1;
                state_nxt = S_B_HI;
            end
            // B ends at N-1, so the last B read at cnt+1 fetches A[0].
            S_B_HI: begin
                sg_step   = 1'b1;
                src_rd    = 1'b1;
                src_addr  = AW'(sg_cnt) + AW'(1);
                state_nxt = sg_tc ? S_BF_LO : S_B_LO;
            end
            S_BF_LO: begin
                sg_lo     = 1'b1;
                state_nxt = S_BF_HI;
            end
            S_BF_HI: begin
                sg_clr    = 1'b1;
                state_nxt = S_A_LO;
            end
            S_A_LO: begin
                sg_lo     = 1'b1;
                state_nxt = S_A_HI;
            end
            S_A_HI: begin
                sg_step = 1'b1;
                if (sg_tc) begin
                    state_nxt = S_AF_LO;
                end else begin
                    src_rd    = 1'b1;
                    src_addr  = AW'(n_q) + AW'(sg_cnt) + AW'(1);
                    state_nxt = S_A_LO;
                end
            end
            S_AF_LO: begin
                sg_lo     = 1'b1;
                state_nxt = S_AF_HI;
            end
            S_AF_HI: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (drdy) begin
                    state_nxt = (fail || n_m1 == 7'd0) ? S_FIN : S_CAP;
                end else if (tmo_hit) begin
                    state_nxt = S_FIN;
                end
            end
            S_CAP: begin
                if (cap_last) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q        <= 7'd1;
            nn_m1      <= '0;
            wcnt       <= '0;
            A_next     <= '0;
            B_next     <= '0;
            res_we     <= 1'b0;
            res_addr   <= '0;
            res_wdata  <= '0;
            solve_fail <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            res_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q        <= clamp_n(n_in);
                        solve_fail <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                S_GO:    nn_m1  <= nn_full - CW'(1);
                S_B_LO:  B_next <= src_rdata;
                // A[0] was read by the last B_HI; it arrives during the B flush.
                S_BF_LO: A_next <= src_rdata;
                S_A_LO: begin
                    if (sg_cnt != '0) begin
                        A_next <= src_rdata;
                    end
                end
                S_AF_HI: wcnt <= '0;
                S_WAIT: begin
                    if (drdy) begin
                        if (fail) begin
                            solve_fail <= 1'b1;
                        end else begin
                            res_we    <= 1'b1;
                            res_addr  <= '0;
                            res_wdata <= dout;
                        end
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt_inc;
                    end
                end
                S_CAP: begin
                    res_we    <= 1'b1;
                    res_addr  <= res_next;
                    res_wdata <= dout;
                end
                default: ;
            endcase
        end
    end

`ifdef JACOBI_HOST_LAT_EN
    // Counts GO through the WAIT cycle that sees drdy, inclusive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                lat_cycles <= '0;
            end
        end else if (state != S_CAP && state != S_FIN && lat_cycles != 16'hFFFF) begin
            lat_cycles <= lat_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jacobi_host_seq.sv
// tb/tb_jacobi_host_seq.sv - Scoreboard bench for jacobi_host_seq
module tb_jacobi_host_seq;

    localparam int DW    = 27;
    localparam int AW    = 15;
    localparam int RW    = 7;
    localparam int TMO_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       n_in = 8'd0;
    logic [TMO_W-1:0] tmo_limit = '0;
    logic [AW-1:0]    src_addr;
    logic             src_rd;
    logic [DW-1:0]    src_rdata = '0;
    logic             go, load_A, load_B;
    logic [DW-1:0]    A_next, B_next;
    logic             drdy = 1'b0;
    logic             fail = 1'b0;
    logic [DW-1:0]    dout = '0;
    logic             res_we;
    logic [RW-1:0]    res_addr;
    logic [DW-1:0]    res_wdata;
    logic             busy, done, solve_fail, timeout;
`ifdef JACOBI_HOST_LAT_EN
    logic [15:0]      lat_cycles;
`endif

    jacobi_host_seq #(.DW(DW), .AW(AW), .RW(RW), .TMO_W(TMO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_in       (n_in),
        .tmo_limit  (tmo_limit),
        .src_addr   (src_addr),
        .src_rd     (src_rd),
        .src_rdata  (src_rdata),
        .go         (go),
        .load_A     (load_A),
        .load_B     (load_B),
        .A_next     (A_next),
        .B_next     (B_next),
        .drdy       (drdy),
        .fail       (fail),
        .dout       (dout),
        .res_we     (res_we),
        .res_addr   (res_addr),
        .res_wdata  (res_wdata),
        .busy       (busy),
        .done       (done),
        .solve_fail (solve_fail),
        .timeout    (timeout)
`ifdef JACOBI_HOST_LAT_EN
        ,
        .lat_cycles (lat_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (src_rd) src_rdata <= src_mem[src_addr];
    end

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_rd[$];
    logic [RW-1:0] exp_ra[$];

    // mode 0: capture, 1: solver fail, 2: watchdog expiry
    task automatic run_seq(input int n_req, input int mode, input int dly,
                           input bit fixed, input bit noisy, input int tmo);
        int n, nn, go_cnt, nb, na, nw, dn, go_c, ld_c, w0, t_c, done_c, drv_i, bad_rd;
        bit pb, pa, in_wait, fin;
        logic [DW-1:0] v;
        logic [DW-1:0] rv [0:126];
        n = (n_req == 0) ? 1 : n_req;
        nn = n * n;
        go_cnt = 0; nb = 0; na = 0; nw = 0; dn = 0; go_c = -1; ld_c = -1;
        w0 = 0; t_c = 0; done_c = 0; drv_i = 0; bad_rd = 0;
        pb = 0; pa = 0; in_wait = 0; fin = 0;
        for (int k = 0; k < n; k++) begin
            v = fixed ? ((k == 0) ? DW'(5) : DW'(-3)) : DW'($urandom);
            src_mem[k] = v;
            exp_b.push_back(v);
        end
        exp_b.push_back(src_mem[n-1]);
        for (int k = 0; k < nn; k++) begin
            if (fixed) v = (k == 0) ? DW'(4) : ((k == 3) ? DW'(3) : DW'(1));
            else       v = DW'($urandom);
            src_mem[n+k] = v;
            exp_a.push_back(v);
        end
        exp_a.push_back(src_mem[n+nn-1]);
        for (int k = 0; k < n; k++) begin
            rv[k] = fixed ? ((k == 0) ? DW'(7) : DW'(-2)) : DW'($urandom);
            if (mode == 0) begin
                exp_ra.push_back(RW'(k));
                exp_rd.push_back(rv[k]);
            end
        end

        @(negedge clk);
        tmo_limit = TMO_W'(tmo);
        n_in = 8'(n_req);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_in = 8'd99;
        for (int c = 0; c < 40000 && !fin; c++) begin
            if (c == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start got %0b exp 1", busy);
                end
                checks++;
                if ({solve_fail, timeout} !== 2'b00) begin
                    errors++;
                    $display("FAIL status_cleared got %b exp 00", {solve_fail, timeout});
                end
            end
            if (noisy && (c % 7 == 3)) begin
                start = 1'b1;
                n_in = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (go) begin
                go_cnt++;
                go_c = c;
            end
            if (src_rd && !(go || load_A || load_B)) bad_rd++;
            if ((load_A || load_B) && ld_c < 0) ld_c = c;
            if (load_B && !pb) begin
                nb++;
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL extra_load_B got %0h exp none", B_next);
                end else begin
                    v = exp_b.pop_front();
                    if (B_next !== v) begin
                        errors++;
                        $display("FAIL B_next[%0d] got %0h exp %0h", nb - 1, B_next, v);
                    end
                end
            end
            if (load_A && !pa) begin
                na++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL extra_load_A got %0h exp none", A_next);
                end else begin
                    v = exp_a.pop_front();
                    if (A_next !== v) begin
                        errors++;
                        $display("FAIL A_next[%0d] got %0h exp %0h", na - 1, A_next, v);
                    end
                end
            end
            if (pa && !load_A && na == nn + 1 && !in_wait) begin
                in_wait = 1;
                w0 = c;
            end
            drdy = 1'b0;
            fail = 1'b0;
            if (in_wait && mode != 2 && c >= w0 + dly && drv_i < n) begin
                if (drv_i == 0) t_c = c;
                drdy = (drv_i == 0) || !noisy || (drv_i % 2 == 1);
                fail = (mode == 1);
                dout = rv[drv_i];
                drv_i = (mode == 1) ? n : drv_i + 1;
            end
            if (res_we) begin
                nw++;
                checks++;
                if (exp_ra.size() == 0) begin
                    errors++;
                    $display("FAIL extra_res_we got addr %0d exp none", res_addr);
                end else begin
                    if ({res_addr, res_wdata} !== {exp_ra[0], exp_rd[0]}) begin
                        errors++;
                        $display("FAIL res_write got %0d:%0h exp %0d:%0h",
                                 res_addr, res_wdata, exp_ra[0], exp_rd[0]);
                    end
                    void'(exp_ra.pop_front());
                    void'(exp_rd.pop_front());
                end
            end
            if (done) begin
                dn++;
                done_c = c;
                fin = 1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done got %0b exp 0", busy);
                end
            end
            pb = load_B;
            pa = load_A;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        drdy = 1'b0;
        fail = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL done_wait got no done exp done within bound");
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
            if (res_we) nw++;
        end
        checks++;
        if (go_cnt !== 1) begin errors++; $display("FAIL go_count got %0d exp 1", go_cnt); end
        checks++;
        if (!(go_c >= 0 && ld_c > go_c)) begin
            errors++;
            $display("FAIL go_before_load got go %0d load %0d exp go earlier", go_c, ld_c);
        end
        checks++;
        if (nb !== n + 1) begin errors++; $display("FAIL load_B_count got %0d exp %0d", nb, n + 1); end
        checks++;
        if (na !== nn + 1) begin errors++; $display("FAIL load_A_count got %0d exp %0d", na, nn + 1); end
        checks++;
        if (nw !== ((mode == 0) ? n : 0)) begin
            errors++;
            $display("FAIL res_we_count got %0d exp %0d", nw, (mode == 0) ? n : 0);
        end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL done_count got %0d exp 1", dn); end
        checks++;
        if ({solve_fail, timeout} !== {(mode == 1), (mode == 2)}) begin
            errors++;
            $display("FAIL status got %b exp %b", {solve_fail, timeout}, {(mode == 1), (mode == 2)});
        end
        checks++;
        if (bad_rd !== 0) begin errors++; $display("FAIL stray_src_rd got %0d exp 0", bad_rd); end
        if (mode == 2) begin
            checks++;
            if (done_c - w0 !== tmo) begin
                errors++;
                $display("FAIL timeout_latency got %0d exp %0d", done_c - w0, tmo);
            end
        end
`ifdef JACOBI_HOST_LAT_EN
        if (mode != 2) begin
            checks++;
            if (lat_cycles !== 16'(t_c - go_c + 1)) begin
                errors++;
                $display("FAIL lat_cycles got %0d exp %0d", lat_cycles, t_c - go_c + 1);
            end
        end
`endif
        exp_b.delete();
        exp_a.delete();
        exp_ra.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({go, load_A, load_B, A_next, B_next, src_rd, src_addr, res_we, res_addr, res_wdata,
             busy, done, solve_fail, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero exp all zero");
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        run_seq(2, 0, 3, 1'b1, 1'b0, 0);
    endtask

    task automatic test_fail();
        run_seq(2, 1, 5, 1'b0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        run_seq(2, 2, 0, 1'b0, 1'b0, 50);
    endtask

    task automatic test_back_to_back();
        run_seq(3, 0, 4, 1'b0, 1'b1, 0);
        run_seq(4, 0, 20, 1'b0, 1'b0, 1000);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dn, bz;
        seen = 0; dn = 0; bz = 0;
        for (int k = 0; k < 12; k++) src_mem[k] = DW'($urandom);
        @(negedge clk);
        n_in = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (load_A) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_A_phase got no load_A exp load_A");
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({go, load_A, load_B, A_next, B_next, src_rd, src_addr, res_we, res_addr, res_wdata,
             busy, done, solve_fail, timeout} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got nonzero exp all zero");
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bz++;
        end
        checks++;
        if ({dn, bz} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL after_abort got done %0d busy %0d exp 0 0", dn, bz);
        end
    endtask

    task automatic test_bounds();
        run_seq(1, 0, 0, 1'b0, 1'b0, 0);
        run_seq(0, 0, 1, 1'b0, 1'b1, 0);
        run_seq(127, 0, 2, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fail();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_bounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
